// File: rtl/lookup2_unmix_pkg.sv
// Shared lookup2 mix definitions: shift/target tables, FSM states and the golden ratio.
// Used by both the forward mixer and lookup2_unmix.
package lookup2_pkg;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  typedef enum logic [1:0] {TGT_A, TGT_B, TGT_C} target_e;

  localparam logic [31:0] GOLDEN = 32'h9e3779b9;

  localparam int unsigned NUM_SUBSTEPS = 9;

  // Indexed by forward sub-step k = 0..8
  localparam logic [4:0] SHIFT_TAB [NUM_SUBSTEPS] = '{
    5'd13, 5'd8, 5'd13, 5'd12, 5'd16, 5'd5, 5'd3, 5'd10, 5'd15
  };

  localparam target_e TARGET_TAB [NUM_SUBSTEPS] = '{
    TGT_A, TGT_B, TGT_C, TGT_A, TGT_B, TGT_C, TGT_A, TGT_B, TGT_C
  };

endpackage

// File: rtl/lookup2_unmix_if.sv
// Valid/ready bus for lookup2_unmix: mixed triple in, recovered triple out.
interface lookup2_unmix_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_c;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, busy
  );
endinterface

// File: rtl/lookup2_unmix_step.sv
// Combinational inverse of one lookup2 mix sub-step, selected by idx_i (0..8).
module lookup2_unmix_step
  import lookup2_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [3:0]  idx_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o
);

  logic [4:0] sh;

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    sh  = '0;
    if (idx_i < 4'd9) begin
      sh = SHIFT_TAB[idx_i];
      case (TARGET_TAB[idx_i])
        TGT_A:   a_o = (a_i ^ (c_i >> sh)) + b_i + c_i;
        TGT_B:   b_o = (b_i ^ (a_i << sh)) + c_i + a_i;
        TGT_C:   c_o = (c_i ^ (b_i >> sh)) + a_i + b_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lookup2_unmix.sv
// Iterative inverse of the lookup2 mix; recovers the pre-mix (a, b, c) triple.
// Define LOOKUP2_UNMIX_FAST_EN to undo a whole round (three sub-steps) per cycle.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a mixed triple
// STEP  | undoing sub-step(s) indexed by step_q, counting down to 0
// DONE  | recovered triple presented until out_ready
module lookup2_unmix
  import lookup2_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  lookup2_unmix_if.slave   bus
);

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [31:0] na, nb, nc;

`ifdef LOOKUP2_UNMIX_FAST_EN
  localparam logic [3:0] STEP_INIT = 4'd2;

  logic [3:0]  base;
  logic [31:0] a1, b1, c1, a2, b2, c2;

  // Round r covers sub-steps 3r..3r+2; undo them highest first (c, b, a)
  assign base = (step_q << 1) + step_q;

  lookup2_unmix_step u_step_c (
    .a_i(a_q), .b_i(b_q), .c_i(c_q), .idx_i(base + 4'd2),
    .a_o(a1),  .b_o(b1),  .c_o(c1)
  );

  lookup2_unmix_step u_step_b (
    .a_i(a1), .b_i(b1), .c_i(c1), .idx_i(base + 4'd1),
    .a_o(a2), .b_o(b2), .c_o(c2)
  );

  lookup2_unmix_step u_step_a (
    .a_i(a2), .b_i(b2), .c_i(c2), .idx_i(base),
    .a_o(na), .b_o(nb), .c_o(nc)
  );
`else
  localparam logic [3:0] STEP_INIT = 4'd8;

  lookup2_unmix_step u_step (
    .a_i(a_q), .b_i(b_q), .c_i(c_q), .idx_i(step_q),
    .a_o(na),  .b_o(nb),  .c_o(nc)
  );
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          c_d     = bus.in_c;
          step_d  = STEP_INIT;
          state_d = STEP;
        end
      end
      STEP: begin
        a_d = na;
        b_d = nb;
        c_d = nc;
        if (step_q == 4'd0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_c     = c_q;

endmodule

// File: tb/tb_lookup2_unmix.sv
// Self-checking bench for lookup2_unmix: forward-mix model generates inputs, the
// original triple is the expected result. Honours LOOKUP2_UNMIX_FAST_EN.
module tb_lookup2_unmix;

`ifdef LOOKUP2_UNMIX_FAST_EN
  localparam int LAT      = 3;
  localparam int SPACING  = 5;
  localparam int MID_WAIT = 1;
`else
  localparam int LAT      = 9;
  localparam int SPACING  = 11;
  localparam int MID_WAIT = 4;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lookup2_unmix_if bus();

  lookup2_unmix dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] in_a, in_b, in_c;
    logic [31:0] exp_a, exp_b, exp_c;
    string       name;
  } vec_t;

  function automatic void fwd_mix(input logic [31:0] a0, b0, c0,
                                  output logic [31:0] a, b, c);
    a = a0; b = b0; c = c0;
    a = (a - b - c) ^ (c >> 13);
    b = (b - c - a) ^ (a << 8);
    c = (c - a - b) ^ (b >> 13);
    a = (a - b - c) ^ (c >> 12);
    b = (b - c - a) ^ (a << 16);
    c = (c - a - b) ^ (b >> 5);
    a = (a - b - c) ^ (c >> 3);
    b = (b - c - a) ^ (a << 10);
    c = (c - a - b) ^ (b >> 15);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_txn(input logic [31:0] a, b, c);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    chk("start_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_c = c;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge CLK); #1; lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
  endtask

  task automatic full_txn(input logic [31:0] ia, ib, ic, ea, eb, ec, input string nm);
    int lat;
    bit bok;
    start_txn(ia, ib, ic);
    wait_out(lat, bok);
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_busy"}, 32'(bok), 32'd1);
    chk({nm, "_a"}, bus.out_a, ea);
    chk({nm, "_b"}, bus.out_b, eb);
    chk({nm, "_c"}, bus.out_c, ec);
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({nm, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t tv[6];
  logic [31:0] pre [6][3];

  initial begin
    logic [31:0] ma, mb, mc, pa, pb, pc;
    logic [31:0] ra, rb, rc;
    int          acc [2];
    int          k, cyc, lat;
    bit          bok, stable;
    logic [31:0] got_a [$];
    logic [31:0] got_b [$];
    logic [31:0] got_c [$];

    pre = '{
      '{32'h0, 32'h0, 32'h0},
      '{32'h9e3779b9, 32'h9e3779b9, 32'hdeadbeef},
      '{32'hffffffff, 32'hffffffff, 32'hffffffff},
      '{32'h1, 32'h2, 32'h3},
      '{32'h80000000, 32'h0, 32'h1},
      '{32'h12345678, 32'hcafef00d, 32'h0badc0de}
    };
    for (int i = 0; i < 6; i++) begin
      fwd_mix(pre[i][0], pre[i][1], pre[i][2], ma, mb, mc);
      tv[i] = '{ma, mb, mc, pre[i][0], pre[i][1], pre[i][2], $sformatf("vec%0d", i)};
    end

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    chk("rst_out_b", bus.out_b, 32'd0);
    chk("rst_out_c", bus.out_c, 32'd0);

    for (int i = 0; i < 6; i++)
      full_txn(tv[i].in_a, tv[i].in_b, tv[i].in_c,
               tv[i].exp_a, tv[i].exp_b, tv[i].exp_c, tv[i].name);

    for (int i = 0; i < 1000; i++) begin
      pa = $urandom; pb = $urandom; pc = $urandom;
      fwd_mix(pa, pb, pc, ma, mb, mc);
      full_txn(ma, mb, mc, pa, pb, pc, "rand");
    end

    // Back-pressure with an ignored second input
    pa = 32'h0f1e2d3c; pb = 32'h4b5a6978; pc = 32'h8796a5b4;
    fwd_mix(pa, pb, pc, ma, mb, mc);
    start_txn(ma, mb, mc);
    wait_out(lat, bok);
    chk("bp_latency", 32'(lat), 32'(LAT));
    ra = bus.out_a; rb = bus.out_b; rc = bus.out_c;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i >= 3 && i < 8);
      bus.in_a = 32'h11111111; bus.in_b = 32'h22222222; bus.in_c = 32'h33333333;
      @(posedge CLK); #1;
      if (bus.out_a !== ra || bus.out_b !== rb || bus.out_c !== rc ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_a", bus.out_a, pa);
    chk("bp_b", bus.out_b, pb);
    chk("bp_c", bus.out_c, pc);
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_not_queued", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-operation
    pa = 32'hdeadbeef; pb = 32'hfeedface; pc = 32'h01234567;
    fwd_mix(pa, pb, pc, ma, mb, mc);
    start_txn(ma, mb, mc);
    repeat (MID_WAIT) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_a", bus.out_a, 32'd0);
    chk("mid_rst_b", bus.out_b, 32'd0);
    chk("mid_rst_c", bus.out_c, 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    full_txn(ma, mb, mc, pa, pb, pc, "post_rst");

    // Back-to-back with out_ready tied high
    fwd_mix(32'haaaa5555, 32'h5555aaaa, 32'h00ff00ff, ma, mb, mc);
    bus.in_a = ma; bus.in_b = mb; bus.in_c = mc;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    k = 0; cyc = 0;
    acc[0] = 0; acc[1] = 0;
    while (got_a.size() < 2 && cyc < 80) begin
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready && k < 2) begin
        acc[k] = cyc; k++;
      end
      if (bus.out_valid) begin
        got_a.push_back(bus.out_a);
        got_b.push_back(bus.out_b);
        got_c.push_back(bus.out_c);
      end
      @(posedge CLK); #1;
      if (k == 1) begin
        fwd_mix(32'h31415926, 32'h27182818, 32'h16180339, ma, mb, mc);
        bus.in_a = ma; bus.in_b = mb; bus.in_c = mc;
      end else if (k == 2) begin
        bus.in_valid = 1'b0;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_count", 32'(got_a.size()), 32'd2);
    chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'(SPACING));
    if (got_a.size() == 2) begin
      chk("b2b_a0", got_a[0], 32'haaaa5555);
      chk("b2b_b0", got_b[0], 32'h5555aaaa);
      chk("b2b_c0", got_c[0], 32'h00ff00ff);
      chk("b2b_a1", got_a[1], 32'h31415926);
      chk("b2b_b1", got_b[1], 32'h27182818);
      chk("b2b_c1", got_c[1], 32'h16180339);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
